multi_interval_timer: RTL and testbench
=======================================

Name: multi_interval_timer

Overview:
- Parametrised multi-channel successor to the single 32-bit Avalon-MM interval timer used in the party-game Nios system.
- NUM_CH independent down-counters, each with its own period, prescaler, one-shot/continuous mode, snapshot and interrupt.
- Exposed through one Avalon-MM slave with a 32-bit data path.
- Drives a per-channel IRQ vector plus a combined IRQ to the Nios interrupt controller.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- CNT_W, 32, counter/period width in bits (8..32).
- PRE_W, 16, prescaler width in bits.
- RESET_PERIOD, 49999, period and counter value after reset (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  $clog2(NUM_CH)+3  {channel, reg[2:0]}.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq_vec  out  NUM_CH  per-channel interrupt.
- irq  out  1  OR of irq_vec.

Behaviour:
- Register map (reg offset within channel):
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Bits[3:0] are stored; START/STOP are also acted on as strobes.
  - 2 PERIOD: [CNT_W-1:0].
  - 3 SNAP: write any value captures the live counter; read returns the captured value.
  - 4 PRESCALE: [PRE_W-1:0]; tick every PRESCALE+1 clocks.
  - 5-7: reserved, read 0, writes ignored.
- Read latency is 1 cycle: readdata is registered from the address every clock. Unused upper bits read 0.
- Reset values: counter = period = RESET_PERIOD; control = 0; prescale = 0; TO = 0; RUN = 0; snap = 0; readdata = 0; irq_vec = 0; irq = 0.
- Prescaler:
  - Counts only while RUN=1.
  - Cleared on START, on a PERIOD write, or when it reaches PRESCALE (at which point it emits a tick).
- Counting, on each tick while RUN=1:
  - Counter != 0: decrement by 1.
  - Counter == 0: reload PERIOD and set TO. If CONT=0, clear RUN.
  - Interval is therefore (PERIOD+1)*(PRESCALE+1) clocks.
- PERIOD write:
  - Next cycle: force-reload counter from the new period, clear prescaler, clear RUN.
  - TO is unaffected.
- Simultaneous events (same cycle):
  - START and STOP: START wins.
  - START and timeout in one-shot mode: RUN stays 1.
  - Status-clear write and timeout: TO stays set (set wins, so no lost event).
  - SNAP write and decrement: captures the pre-decrement value.
- Zero period in continuous mode: timeout on every tick; TO stays set until cleared.
- irq_vec[i] = TO[i] & ITO[i], combinational from registers, so no glitch on reset.
- Channels are fully independent. Writes to one channel never affect another.
- Reset asserted mid-count returns all state to reset values on the same edge.

Decomposition:
- Shared package multi_timer_pkg:
  - register offsets (REG_STATUS .. REG_PRESCALE)
  - CONTROL bit indices (ITO=0, CONT=1, START=2, STOP=3)
  - STATUS bit indices (TO=0, RUN=1)
- One sub-module, timer_channel:
  - holds the prescaler, counter, period, snapshot, control, TO and RUN for one channel.
  - is instantiated NUM_CH times by a generate loop.
  - takes decoded per-register write strobes plus writedata.
- The top level does address decode, the registered read mux and the IRQ OR.

Test Plan:
- Reset then read ch0 PERIOD: readdata = 49999 one cycle after the read; STATUS = 0; irq = 0.
- ch1: PERIOD=9, PRESCALE=0, CONTROL=0x7 (ITO, CONT, START): TO sets every 10 clocks; irq_vec = 0b0010; a STATUS write clears it; RUN stays 1.
- ch2: PERIOD=3, PRESCALE=4, CONTROL=0x5 (one-shot): TO sets 20 clocks after START; RUN = 0 afterwards; counter = 3.
- ch0 running: write SNAP, read SNAP: value equals the counter on the write cycle. A PERIOD write while running: RUN = 0 and counter = new period after 1 cycle.
- Status-clear write on the exact timeout cycle: TO reads 1 afterwards. CONTROL=0xC (START and STOP together): RUN = 1.
- Two channels with periods 5 and 7, continuous: TO events are independent; irq stays 1 while either TO&ITO holds. Assert reset mid-count: all outputs are 0 on the same edge.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel interval timer: register offsets
// within a channel window and bit positions inside STATUS and CONTROL.
package multi_timer_pkg;

    // Register offsets inside one channel's 8-word window
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAP     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    // CONTROL bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // STATUS bit positions
    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    // Width of the channel-select field of the address; at least 1 so that
    // a single-channel build still has a legal vector to carry it.
    function automatic int ch_sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One independent timer channel: prescaler, down-counter, period, snapshot,
// stored control bits and the TO/RUN status flags.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 16,
    parameter int RESET_PERIOD = 49999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_status,
    input  logic             wr_control,
    input  logic             wr_period,
    input  logic             wr_snap,
    input  logic             wr_prescale,
    input  logic [31:0]      writedata,
    output logic             to_flag,
    output logic             run_flag,
    output logic [3:0]       control,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] snap,
    output logic [PRE_W-1:0] prescale
);

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] counter;
    logic [PRE_W-1:0] pre_cnt;
    logic             start_req;
    logic             stop_req;
    logic             tick;
    logic             expire;
    logic             unused_wd;

    // Only the low data bits matter for narrow builds
    assign unused_wd = ^writedata;

    assign start_req = wr_control & writedata[CTRL_START];
    assign stop_req  = wr_control & writedata[CTRL_STOP];

    // '>=' rather than '==' so a PRESCALE shrunk below the live prescaler
    // value still produces a tick instead of wrapping the whole range.
    assign tick   = run_flag & (pre_cnt >= prescale);
    assign expire = tick & (counter == '0);

    // Prescaler: free-runs only while RUN, restarts on START or PERIOD write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (wr_period || start_req) begin
            pre_cnt <= '0;
        end else if (run_flag) begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    // Down-counter: PERIOD write force-reloads, otherwise step on each tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= RST_CNT;
        end else if (wr_period) begin
            counter <= writedata[CNT_W-1:0];
        end else if (tick) begin
            if (counter == '0) begin
                counter <= period;
            end else begin
                counter <= counter - CNT_W'(1);
            end
        end
    end

    // Software-visible configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period   <= RST_CNT;
            prescale <= '0;
            control  <= '0;
        end else begin
            if (wr_period) begin
                period <= writedata[CNT_W-1:0];
            end
            if (wr_prescale) begin
                prescale <= writedata[PRE_W-1:0];
            end
            if (wr_control) begin
                control <= writedata[3:0];
            end
        end
    end

    // Snapshot captures the counter as it stands before this edge's update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap <= '0;
        end else if (wr_snap) begin
            snap <= counter;
        end
    end

    // TO flag: a timeout beats a same-cycle clear so no event is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_flag <= 1'b0;
        end else if (expire) begin
            to_flag <= 1'b1;
        end else if (wr_status) begin
            to_flag <= 1'b0;
        end
    end

    // RUN flag: PERIOD write stops, then START over STOP over one-shot end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_flag <= 1'b0;
        end else if (wr_period) begin
            run_flag <= 1'b0;
        end else if (start_req) begin
            run_flag <= 1'b1;
        end else if (stop_req) begin
            run_flag <= 1'b0;
        end else if (expire && !control[CTRL_CONT]) begin
            run_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer: address decode into per-channel
// write strobes, registered read mux, and per-channel / combined IRQs.
module multi_interval_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 16,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(NUM_CH)+2:0]  address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic [NUM_CH-1:0]          irq_vec,
    output logic                       irq
);

    localparam int AW   = $clog2(NUM_CH) + 3;
    localparam int CH_W = ch_sel_width(NUM_CH);
    localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];

    logic [CH_W-1:0]                ch_sel;
    logic [2:0]                     reg_sel;
    logic                           ch_valid;
    logic                           bus_wr;
    logic [31:0]                    rd_next;

    logic [NUM_CH-1:0]              to_q;
    logic [NUM_CH-1:0]              run_q;
    logic [NUM_CH-1:0]              ito_q;
    logic [NUM_CH-1:0][3:0]         ctrl_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   period_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   snap_q;
    logic [NUM_CH-1:0][PRE_W-1:0]   pre_q;

    generate
        if (NUM_CH > 1) begin : g_multi
            assign ch_sel = address[AW-1:3];
        end else begin : g_single
            assign ch_sel = '0;
        end
    endgenerate

    assign reg_sel  = address[2:0];
    assign ch_valid = ({1'b0, ch_sel} < NUM_CH_L);
    assign bus_wr   = chipselect & ~write_n;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic ch_wr;

            assign ch_wr      = bus_wr && (ch_sel == CH_W'(i));
            assign ito_q[i]   = ctrl_q[i][CTRL_ITO];

            timer_channel #(
                .CNT_W        (CNT_W),
                .PRE_W        (PRE_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_channel (
                .clk         (clk),
                .reset       (reset),
                .wr_status   (ch_wr && (reg_sel == REG_STATUS)),
                .wr_control  (ch_wr && (reg_sel == REG_CONTROL)),
                .wr_period   (ch_wr && (reg_sel == REG_PERIOD)),
                .wr_snap     (ch_wr && (reg_sel == REG_SNAP)),
                .wr_prescale (ch_wr && (reg_sel == REG_PRESCALE)),
                .writedata   (writedata),
                .to_flag     (to_q[i]),
                .run_flag    (run_q[i]),
                .control     (ctrl_q[i]),
                .period      (period_q[i]),
                .snap        (snap_q[i]),
                .prescale    (pre_q[i])
            );
        end
    endgenerate

    // Read mux: select the addressed register, zero-extended to 32 bits
    always_comb begin
        rd_next = '0;
        if (ch_valid) begin
            case (reg_sel)
                REG_STATUS: begin
                    rd_next[STAT_TO]  = to_q[ch_sel];
                    rd_next[STAT_RUN] = run_q[ch_sel];
                end
                REG_CONTROL:  rd_next[3:0]       = ctrl_q[ch_sel];
                REG_PERIOD:   rd_next[CNT_W-1:0] = period_q[ch_sel];
                REG_SNAP:     rd_next[CNT_W-1:0] = snap_q[ch_sel];
                REG_PRESCALE: rd_next[PRE_W-1:0] = pre_q[ch_sel];
                default:      rd_next            = '0;
            endcase
        end
    end

    // readdata follows the address every clock, giving one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    // Interrupts are decoded straight from registers so reset leaves them low
    assign irq_vec = to_q & ito_q;
    assign irq     = |irq_vec;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Directed testbench for multi_interval_timer with hand-computed expectations.
module tb_multi_interval_timer;

    localparam int NUM_CH = 4;
    localparam logic [2:0] R_STATUS   = 3'd0;
    localparam logic [2:0] R_CONTROL  = 3'd1;
    localparam logic [2:0] R_PERIOD   = 3'd2;
    localparam logic [2:0] R_SNAP     = 3'd3;
    localparam logic [2:0] R_PRESCALE = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  irq_vec;
    logic        irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    multi_interval_timer #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (32),
        .PRE_W        (16),
        .RESET_PERIOD (49999)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_vec    (irq_vec),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the write lands on the next posedge, returns at the following negedge
    task automatic bus_write(input int ch, input logic [2:0] r, input logic [31:0] d);
        logic [1:0] c;
        c = ch[1:0];
        address    = {c, r};
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Called at a negedge; readdata is registered on the next posedge
    task automatic bus_read(input int ch, input logic [2:0] r, output logic [31:0] d);
        logic [1:0] c;
        c = ch[1:0];
        address    = {c, r};
        chipselect = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    // Counts negedges until the given irq_vec bit rises, bounded at 100
    task automatic wait_irq(input int bitno, output int cycles);
        cycles = 0;
        while (!irq_vec[bitno] && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (irq_vec !== 4'b0000 || irq !== 1'b0)
            $display("FAIL reset_irq: irq_vec=%b irq=%b, expected 0000/0", irq_vec, irq);
        else pass_cnt++;
        reset = 1'b0;
        bus_read(0, R_PERIOD, d);
        total_cnt++;
        if (d !== 32'd49999) $display("FAIL reset_period: got %0d expected 49999", d);
        else pass_cnt++;
        bus_read(0, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reset_status: got %0h expected 0", d);
        else pass_cnt++;
        bus_read(2, R_CONTROL, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reset_control: got %0h expected 0", d);
        else pass_cnt++;
        bus_read(3, R_PRESCALE, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reset_prescale: got %0h expected 0", d);
        else pass_cnt++;
        bus_read(1, R_SNAP, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reset_snap: got %0h expected 0", d);
        else pass_cnt++;
        bus_read(1, R_PERIOD, d);
        total_cnt++;
        if (d !== 32'd49999) $display("FAIL reset_period_ch1: got %0d expected 49999", d);
        else pass_cnt++;
        bus_write(0, 3'd5, 32'hFFFF_FFFF);
        bus_read(0, 3'd5, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reserved_reg: got %0h expected 0", d);
        else pass_cnt++;
    endtask

    task automatic test_continuous();
        logic [31:0] d;
        int cyc;
        bus_write(1, R_PERIOD, 32'd9);
        bus_write(1, R_PRESCALE, 32'd0);
        bus_write(1, R_CONTROL, 32'h7);
        wait_irq(1, cyc);
        total_cnt++;
        if (cyc !== 10) $display("FAIL cont_first_to: %0d cycles, expected 10", cyc);
        else pass_cnt++;
        total_cnt++;
        if (irq_vec !== 4'b0010 || irq !== 1'b1)
            $display("FAIL cont_irq_vec: irq_vec=%b irq=%b, expected 0010/1", irq_vec, irq);
        else pass_cnt++;
        bus_write(1, R_STATUS, 32'd0);
        total_cnt++;
        if (irq_vec !== 4'b0000 || irq !== 1'b0)
            $display("FAIL cont_clear: irq_vec=%b irq=%b, expected 0000/0", irq_vec, irq);
        else pass_cnt++;
        bus_read(1, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd2) $display("FAIL cont_status: got %0h expected 2", d);
        else pass_cnt++;
        wait_irq(1, cyc);
        total_cnt++;
        if (cyc !== 8) $display("FAIL cont_second_to: %0d cycles, expected 8", cyc);
        else pass_cnt++;
        bus_write(1, R_CONTROL, 32'h8);
        bus_write(1, R_STATUS, 32'd0);
        bus_read(1, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL cont_stop: got %0h expected 0", d);
        else pass_cnt++;
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        int cyc;
        bus_write(2, R_PERIOD, 32'd3);
        bus_write(2, R_PRESCALE, 32'd4);
        bus_write(2, R_CONTROL, 32'h5);
        wait_irq(2, cyc);
        total_cnt++;
        if (cyc !== 20) $display("FAIL oneshot_to: %0d cycles, expected 20", cyc);
        else pass_cnt++;
        total_cnt++;
        if (irq_vec !== 4'b0100) $display("FAIL oneshot_irq_vec: got %b expected 0100", irq_vec);
        else pass_cnt++;
        bus_read(2, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd1) $display("FAIL oneshot_status: got %0h expected 1", d);
        else pass_cnt++;
        bus_write(2, R_SNAP, 32'd0);
        bus_read(2, R_SNAP, d);
        total_cnt++;
        if (d !== 32'd3) $display("FAIL oneshot_counter: got %0d expected 3", d);
        else pass_cnt++;
        bus_write(2, R_STATUS, 32'd0);
        bus_write(2, R_CONTROL, 32'h0);
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        bus_write(0, R_PERIOD, 32'd1000);
        bus_write(0, R_CONTROL, 32'h6);
        repeat (5) @(negedge clk);
        bus_write(0, R_SNAP, 32'hDEAD_BEEF);
        bus_read(0, R_SNAP, d);
        total_cnt++;
        if (d !== 32'd995) $display("FAIL snap_running: got %0d expected 995", d);
        else pass_cnt++;
        bus_write(0, R_PERIOD, 32'd500);
        bus_read(0, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL period_write_stop: got %0h expected 0", d);
        else pass_cnt++;
        bus_write(0, R_SNAP, 32'd0);
        bus_read(0, R_SNAP, d);
        total_cnt++;
        if (d !== 32'd500) $display("FAIL period_reload: got %0d expected 500", d);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        int cyc;
        bus_write(3, R_PERIOD, 32'd4);
        bus_write(3, R_CONTROL, 32'h7);
        repeat (4) @(negedge clk);
        bus_write(3, R_STATUS, 32'd0);
        total_cnt++;
        if (irq_vec !== 4'b1000) $display("FAIL clear_vs_timeout_irq: got %b expected 1000", irq_vec);
        else pass_cnt++;
        bus_read(3, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd3) $display("FAIL clear_vs_timeout_status: got %0h expected 3", d);
        else pass_cnt++;
        bus_write(3, R_CONTROL, 32'h8);
        bus_read(3, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd1) $display("FAIL stop_status: got %0h expected 1", d);
        else pass_cnt++;
        bus_write(3, R_CONTROL, 32'hC);
        bus_read(3, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd3) $display("FAIL start_stop_status: got %0h expected 3", d);
        else pass_cnt++;
        bus_read(3, R_CONTROL, d);
        total_cnt++;
        if (d !== 32'hC) $display("FAIL start_stop_control: got %0h expected c", d);
        else pass_cnt++;
        // START landing on the one-shot timeout edge keeps the channel running
        bus_write(3, R_PERIOD, 32'd2);
        bus_write(3, R_STATUS, 32'd0);
        bus_write(3, R_CONTROL, 32'h5);
        repeat (2) @(negedge clk);
        bus_write(3, R_CONTROL, 32'h5);
        total_cnt++;
        if (irq_vec !== 4'b1000) $display("FAIL start_vs_oneshot_irq: got %b expected 1000", irq_vec);
        else pass_cnt++;
        bus_read(3, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd3) $display("FAIL start_vs_oneshot_status: got %0h expected 3", d);
        else pass_cnt++;
        // Zero period, prescale 1: timeout on every second clock
        bus_write(3, R_PERIOD, 32'd0);
        bus_write(3, R_PRESCALE, 32'd1);
        bus_write(3, R_STATUS, 32'd0);
        bus_write(3, R_CONTROL, 32'h7);
        wait_irq(3, cyc);
        total_cnt++;
        if (cyc !== 2) $display("FAIL zero_period_first: %0d cycles, expected 2", cyc);
        else pass_cnt++;
        bus_write(3, R_STATUS, 32'd0);
        total_cnt++;
        if (irq_vec !== 4'b0000) $display("FAIL zero_period_clear: got %b expected 0000", irq_vec);
        else pass_cnt++;
        wait_irq(3, cyc);
        total_cnt++;
        if (cyc !== 1) $display("FAIL zero_period_next: %0d cycles, expected 1", cyc);
        else pass_cnt++;
        bus_write(3, R_CONTROL, 32'h8);
        bus_write(3, R_STATUS, 32'd0);
        bus_write(3, R_PRESCALE, 32'd0);
    endtask

    task automatic test_two_channels();
        logic [31:0] d;
        bus_write(0, R_PERIOD, 32'd5);
        bus_write(1, R_PERIOD, 32'd7);
        bus_write(0, R_CONTROL, 32'h7);
        bus_write(1, R_CONTROL, 32'h7);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (irq_vec !== 4'b0000 || irq !== 1'b0)
            $display("FAIL two_ch_idle: irq_vec=%b irq=%b, expected 0000/0", irq_vec, irq);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (irq_vec !== 4'b0001 || irq !== 1'b1)
            $display("FAIL two_ch_ch0: irq_vec=%b irq=%b, expected 0001/1", irq_vec, irq);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (irq_vec !== 4'b0011) $display("FAIL two_ch_both: got %b expected 0011", irq_vec);
        else pass_cnt++;
        bus_write(0, R_STATUS, 32'd0);
        total_cnt++;
        if (irq_vec !== 4'b0010 || irq !== 1'b1)
            $display("FAIL two_ch_clear0: irq_vec=%b irq=%b, expected 0010/1", irq_vec, irq);
        else pass_cnt++;
        bus_write(1, R_STATUS, 32'd0);
        total_cnt++;
        if (irq_vec !== 4'b0000 || irq !== 1'b0)
            $display("FAIL two_ch_clear1: irq_vec=%b irq=%b, expected 0000/0", irq_vec, irq);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (irq_vec !== 4'b0001) $display("FAIL two_ch_ch0_again: got %b expected 0001", irq_vec);
        else pass_cnt++;
        bus_read(1, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd2) $display("FAIL two_ch_ch1_status: got %0h expected 2", d);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] d;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (irq_vec !== 4'b0000 || irq !== 1'b0 || readdata !== 32'd0)
            $display("FAIL async_reset: irq_vec=%b irq=%b readdata=%0h, expected all 0",
                     irq_vec, irq, readdata);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        bus_read(0, R_PERIOD, d);
        total_cnt++;
        if (d !== 32'd49999) $display("FAIL reset_mid_period: got %0d expected 49999", d);
        else pass_cnt++;
        bus_read(0, R_STATUS, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reset_mid_status: got %0h expected 0", d);
        else pass_cnt++;
        bus_read(1, R_CONTROL, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reset_mid_control: got %0h expected 0", d);
        else pass_cnt++;
        repeat (12) @(negedge clk);
        total_cnt++;
        if (irq_vec !== 4'b0000) $display("FAIL reset_mid_idle: got %b expected 0000", irq_vec);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_one_shot();
        test_snapshot();
        test_simultaneous();
        test_two_channels();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
